// File: rtl/pr_pkg.sv
// rtl/pr_pkg.sv - shared types and phase constants for the multi-channel peak/phase stage
package pr_pkg;

  localparam int PI_Q13     = 25736;
  localparam int TWO_PI_Q13 = 51472;

  typedef logic signed [15:0] phase_t;

  typedef enum logic [1:0] {
    IDLE,
    REF,
    CAPT,
    EMIT
  } state_t;

endpackage

// File: rtl/multi_phase_detect_if.sv
// rtl/multi_phase_detect_if.sv - polar bin sink stream and phase-difference source stream
interface multi_phase_detect_if
  import pr_pkg::*;
#(
  parameter int NCH    = 3,
  parameter int MWIDTH = 25
) ();

  localparam int CHW = $clog2(NCH);

  logic              sink_valid;
  logic              sink_sop;
  logic              sink_eop;
  logic [MWIDTH-1:0] sink_mag;
  phase_t            sink_phase;

  logic              source_valid;
  logic              source_sop;
  logic              source_eop;
  logic [CHW-1:0]    source_chan;
  logic [23:0]       source_freq;
  phase_t            source_phase;
  logic              lowmag;
  logic              error;

  modport master (
    output sink_valid, sink_sop, sink_eop, sink_mag, sink_phase,
    input  source_valid, source_sop, source_eop, source_chan, source_freq, source_phase,
    input  lowmag, error
  );

  modport slave (
    input  sink_valid, sink_sop, sink_eop, sink_mag, sink_phase,
    output source_valid, source_sop, source_eop, source_chan, source_freq, source_phase,
    output lowmag, error
  );

endinterface

// File: rtl/multi_phase_detect_phase_diff_wrap.sv
// rtl/multi_phase_detect_phase_diff_wrap.sv - Q3.13 phase subtract wrapped into [-pi, pi)
module phase_diff_wrap
  import pr_pkg::*;
(
  input  phase_t ph_ch_i,
  input  phase_t ph_ref_i,
  output phase_t diff_o
);

  localparam logic signed [16:0] WRAP_HI = 17'(PI_Q13 - 1);
  localparam logic signed [16:0] WRAP_LO = 17'(-PI_Q13);
  localparam logic signed [16:0] TWO_PI  = 17'(TWO_PI_Q13);

  logic signed [16:0] raw;
  logic signed [16:0] wrapped;

  always_comb begin
    raw     = $signed({ph_ch_i[15], ph_ch_i}) - $signed({ph_ref_i[15], ph_ref_i});
    wrapped = raw;
    if (raw > WRAP_HI) begin
      wrapped = raw - TWO_PI;
    end else if (raw < WRAP_LO) begin
      wrapped = raw + TWO_PI;
    end
    diff_o = wrapped[15:0];
  end

endmodule

// File: rtl/multi_phase_detect.sv
// rtl/multi_phase_detect.sv - reference-channel peak search, per-channel phase capture, burst of wrapped differences
module multi_phase_detect
  import pr_pkg::*;
#(
  parameter int NCH    = 3,
  parameter int FFT    = 11,
  parameter int MWIDTH = 25,
  parameter int BIN_HZ = 9766,
  parameter int THRESH = 4096
) (
  input logic                 clk,
  input logic                 reset,
  multi_phase_detect_if.slave pd
);

  localparam int CHW = $clog2(NCH);
  localparam int CW  = FFT + CHW;
  localparam int FW  = FFT + 32;

  localparam logic [CW-1:0]     LAST_CNT = CW'(NCH * (2 ** FFT) - 1);
  localparam logic [CW-1:0]     REF_LAST = CW'(2 ** FFT - 1);
  localparam logic [FFT-1:0]    POS_LAST = FFT'(2 ** (FFT - 1) - 1);
  localparam logic [MWIDTH-1:0] THRESH_M = MWIDTH'(THRESH);
  localparam logic [FW-1:0]     BIN_HZ_W = FW'(BIN_HZ);
  localparam logic [FW-1:0]     FREQ_MAX = FW'(24'hFFFFFF);
  localparam logic [CHW-1:0]    LAST_CH  = CHW'(NCH - 1);

  // Scan side
  state_t            scan_q;
  logic [CW-1:0]     cnt_q;
  logic [FFT-1:0]    peak_bin_q;
  logic [MWIDTH-1:0] peak_mag_q;
  logic              found_q;
  phase_t            ref_ph_q;
  phase_t            slot_q [NCH];
  logic              error_q;
  logic              lowmag_q;

  // Output bank, independent so a new scan can overlap the burst
  state_t            out_q;
  logic [CHW-1:0]    emit_ch_q;
  phase_t            bank_slot_q [NCH];
  phase_t            bank_ref_q;
  logic [23:0]       bank_freq_q;
  logic              src_valid_q;
  logic              src_sop_q;
  logic              src_eop_q;
  logic [CHW-1:0]    src_chan_q;
  logic [23:0]       src_freq_q;
  phase_t            src_phase_q;

  logic [FFT-1:0]    bin;
  logic [CHW-1:0]    ch;
  logic              consider;
  logic              frame_end;
  logic              keep_frame;
  logic              load_bank;
  logic [FW-1:0]     prod;
  logic [23:0]       freq_d;
  phase_t            diff_d;

  assign bin        = cnt_q[FFT-1:0];
  assign ch         = cnt_q[CW-1:FFT];
  assign consider   = (scan_q == REF) && (bin != '0) && (bin <= POS_LAST) &&
                      (pd.sink_mag > peak_mag_q);
  assign frame_end  = pd.sink_valid && !pd.sink_sop && pd.sink_eop &&
                      (scan_q == CAPT) && (cnt_q == LAST_CNT);
  assign keep_frame = found_q && (peak_mag_q >= THRESH_M);
  assign load_bank  = frame_end && keep_frame;
  assign prod       = FW'(peak_bin_q) * BIN_HZ_W;
  assign freq_d     = (prod > FREQ_MAX) ? 24'hFFFFFF : prod[23:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_q     <= IDLE;
      cnt_q      <= '0;
      peak_bin_q <= '0;
      peak_mag_q <= '0;
      found_q    <= 1'b0;
      ref_ph_q   <= '0;
      error_q    <= 1'b0;
      lowmag_q   <= 1'b0;
      for (int i = 0; i < NCH; i++) slot_q[i] <= '0;
    end else begin
      error_q  <= 1'b0;
      lowmag_q <= 1'b0;
      if (pd.sink_valid) begin
        case (scan_q)
          IDLE: begin
            if (pd.sink_sop) begin
              if (pd.sink_eop) begin
                error_q <= 1'b1;
              end else begin
                scan_q     <= REF;
                cnt_q      <= CW'(1);
                found_q    <= 1'b0;
                peak_mag_q <= '0;
                peak_bin_q <= '0;
              end
            end
          end
          REF, CAPT: begin
            if (pd.sink_sop) begin
              // the offending sop becomes beat 0 of a fresh frame
              error_q    <= 1'b1;
              scan_q     <= pd.sink_eop ? IDLE : REF;
              cnt_q      <= CW'(1);
              found_q    <= 1'b0;
              peak_mag_q <= '0;
              peak_bin_q <= '0;
            end else if (cnt_q == LAST_CNT) begin
              scan_q <= IDLE;
              if (!pd.sink_eop) begin
                error_q <= 1'b1;
              end else if (!keep_frame) begin
                lowmag_q <= 1'b1;
              end
            end else if (pd.sink_eop) begin
              error_q <= 1'b1;
              scan_q  <= IDLE;
            end else begin
              cnt_q <= cnt_q + CW'(1);
              if (cnt_q == REF_LAST) scan_q <= CAPT;
              if (consider) begin
                found_q    <= 1'b1;
                peak_mag_q <= pd.sink_mag;
                peak_bin_q <= bin;
                ref_ph_q   <= pd.sink_phase;
              end
              if ((scan_q == CAPT) && (bin == peak_bin_q)) slot_q[ch] <= pd.sink_phase;
            end
          end
          default: scan_q <= IDLE;
        endcase
      end
    end
  end

  phase_diff_wrap u_wrap (
    .ph_ch_i  (bank_slot_q[emit_ch_q]),
    .ph_ref_i (bank_ref_q),
    .diff_o   (diff_d)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q       <= IDLE;
      emit_ch_q   <= '0;
      bank_ref_q  <= '0;
      bank_freq_q <= '0;
      src_valid_q <= 1'b0;
      src_sop_q   <= 1'b0;
      src_eop_q   <= 1'b0;
      src_chan_q  <= '0;
      src_freq_q  <= '0;
      src_phase_q <= '0;
      for (int i = 0; i < NCH; i++) bank_slot_q[i] <= '0;
    end else begin
      src_valid_q <= 1'b0;
      src_sop_q   <= 1'b0;
      src_eop_q   <= 1'b0;
      src_chan_q  <= '0;
      src_freq_q  <= '0;
      src_phase_q <= '0;
      if (load_bank) begin
        bank_slot_q <= slot_q;
        bank_ref_q  <= ref_ph_q;
        bank_freq_q <= freq_d;
        emit_ch_q   <= CHW'(1);
        out_q       <= EMIT;
      end else if (out_q == EMIT) begin
        src_valid_q <= 1'b1;
        src_sop_q   <= (emit_ch_q == CHW'(1));
        src_eop_q   <= (emit_ch_q == LAST_CH);
        src_chan_q  <= emit_ch_q;
        src_freq_q  <= bank_freq_q;
        src_phase_q <= diff_d;
        if (emit_ch_q == LAST_CH) begin
          out_q <= IDLE;
        end else begin
          emit_ch_q <= emit_ch_q + CHW'(1);
        end
      end
    end
  end

  assign pd.source_valid = src_valid_q;
  assign pd.source_sop   = src_sop_q;
  assign pd.source_eop   = src_eop_q;
  assign pd.source_chan  = src_chan_q;
  assign pd.source_freq  = src_freq_q;
  assign pd.source_phase = src_phase_q;
  assign pd.lowmag       = lowmag_q;
  assign pd.error        = error_q;

endmodule
